// File: rtl/cmd_pkg.sv
// Shared command-word definitions for the command encoder and decoder.
// Flag bit positions, field offsets and the encoder FSM state type.
package cmd_pkg;

    localparam int ON_BIT        = 0;
    localparam int OFF_BIT       = 1;
    localparam int INC_BIT       = 2;
    localparam int DEC_BIT       = 3;
    localparam int RECV_BIT      = 4;
    localparam int SEND_BIT      = 5;
    localparam int QUALIFIER_BIT = 6;
    localparam int RESERVED_BIT  = 7;

    localparam int FIELD_WIDTH = 8;
    localparam int AMOUNT_LSB  = 8;
    localparam int SEQ_LSB     = 16;
    localparam int CSUM_LSB    = 24;
    localparam int WORD_WIDTH  = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/cmd_checksum.sv
// Checksum byte of a command word: XOR of the flags, amount and sequence bytes.
module cmd_checksum
    import cmd_pkg::*;
(
    input  logic [3*FIELD_WIDTH-1:0] low_bytes,
    output logic [FIELD_WIDTH-1:0]   checksum
);

    assign checksum = low_bytes[0 +: FIELD_WIDTH]
                    ^ low_bytes[FIELD_WIDTH +: FIELD_WIDTH]
                    ^ low_bytes[2*FIELD_WIDTH +: FIELD_WIDTH];

endmodule

// File: rtl/cmd_encoder.sv
// Packs requested command flags into a checksummed, sequence-numbered word and
// hands it downstream over a valid/ready link, one word at a time.
module cmd_encoder
    import cmd_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int AMOUNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    on,
    input  logic                    off,
    input  logic                    increase,
    input  logic                    decrease,
    input  logic                    send,
    input  logic                    receive,
    input  logic [AMOUNT_WIDTH-1:0] amount,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    err_conflict,
    output logic [7:0]              seq
);

    state_e                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [7:0]                seq_q, seq_d;
    logic                      err_q, err_d;
    logic                      active_q, active_d;

    logic [FIELD_WIDTH-1:0]    flags_byte;
    logic [FIELD_WIDTH-1:0]    amount_byte;
    logic [3*FIELD_WIDTH-1:0]  low_bytes;
    logic [FIELD_WIDTH-1:0]    checksum;
    logic [WORD_WIDTH-1:0]     word;
    logic                      conflict;

    always_comb begin
        flags_byte                = '0;
        flags_byte[ON_BIT]        = on;
        flags_byte[OFF_BIT]       = off;
        flags_byte[INC_BIT]       = increase;
        flags_byte[DEC_BIT]       = decrease;
        flags_byte[RECV_BIT]      = receive;
        flags_byte[SEND_BIT]      = send;
        flags_byte[QUALIFIER_BIT] = 1'b1;
        flags_byte[RESERVED_BIT]  = 1'b0;
        // A step size only means something alongside increase/decrease.
        amount_byte = (increase || decrease) ? FIELD_WIDTH'(amount) : '0;
    end

    assign low_bytes = {seq_q, amount_byte, flags_byte};

    cmd_checksum u_checksum (
        .low_bytes (low_bytes),
        .checksum  (checksum)
    );

    always_comb begin
        word                                = '0;
        word[0 +: FIELD_WIDTH]              = flags_byte;
        word[AMOUNT_LSB +: FIELD_WIDTH]     = amount_byte;
        word[SEQ_LSB +: FIELD_WIDTH]        = seq_q;
        word[CSUM_LSB +: FIELD_WIDTH]       = checksum;
    end

    assign conflict = (on && off) || (increase && decrease);

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        seq_d    = seq_q;
        err_d    = 1'b0;
        active_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    if (conflict) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                        data_d  = DATA_WIDTH'(word);
                    end
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                    seq_d   = seq_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // active_q keeps req_ready low until the first clock edge out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            seq_q    <= '0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            seq_q    <= seq_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

    assign req_ready    = active_q && (state_q == ST_IDLE);
    assign tx_valid     = (state_q == ST_SEND);
    assign tx_data      = data_q;
    assign err_conflict = err_q;
    assign seq          = seq_q;

endmodule

// File: tb/tb_cmd_encoder.sv
// Self-checking bench for cmd_encoder: directed requests feed a scoreboard queue
// that a negedge monitor drains on every tx handshake.
module tb_cmd_encoder;

    localparam logic [5:0] F_NONE = 6'b000000;
    localparam logic [5:0] F_ON   = 6'b000001;
    localparam logic [5:0] F_OFF  = 6'b000010;
    localparam logic [5:0] F_INC  = 6'b000100;
    localparam logic [5:0] F_DEC  = 6'b001000;
    localparam logic [5:0] F_RECV = 6'b010000;
    localparam logic [5:0] F_SEND = 6'b100000;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        on, off, increase, decrease, send, receive;
    logic [7:0]  amount;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        err_conflict;
    logic [7:0]  seq;

    int          checks;
    int          failures;
    logic [31:0] exp_q[$];
    logic [7:0]  model_seq;

    cmd_encoder #(
        .DATA_WIDTH   (32),
        .AMOUNT_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .on           (on),
        .off          (off),
        .increase     (increase),
        .decrease     (decrease),
        .send         (send),
        .receive      (receive),
        .amount       (amount),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .err_conflict (err_conflict),
        .seq          (seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoding built straight from the documented word layout.
    function automatic logic [31:0] model_word(input logic [5:0] f, input logic [7:0] amt,
                                               input logic [7:0] s);
        logic [7:0] b0, b1;
        b0 = {2'b01, f};
        b1 = (f[2] || f[3]) ? amt : 8'h00;
        return {b0 ^ b1 ^ s, s, b1, b0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic driveFlags(input logic [5:0] f, input logic [7:0] amt);
        on       = f[0];
        off      = f[1];
        increase = f[2];
        decrease = f[3];
        receive  = f[4];
        send     = f[5];
        amount   = amt;
    endtask

    // Issues one request; conflicting requests are checked here, good ones go to the scoreboard.
    task automatic applyStimulus(input logic [5:0] f, input logic [7:0] amt,
                                 input logic [31:0] exp_word, input bit is_conflict);
        int waited;
        waited = 0;
        while (!req_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!req_ready) begin
            checkOutput("req_ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        driveFlags(f, amt);
        req_valid = 1'b1;
        if (!is_conflict) exp_q.push_back(exp_word);
        step();
        req_valid = 1'b0;
        driveFlags(F_NONE, 8'h00);
        if (is_conflict) begin
            checkOutput("err_pulse", 32'(err_conflict), 32'd1);
            checkOutput("no_tx_on_conflict", 32'(tx_valid), 32'd0);
            checkOutput("seq_kept_on_conflict", 32'(seq), 32'(model_seq));
            step();
            checkOutput("err_one_cycle", 32'(err_conflict), 32'd0);
            checkOutput("no_tx_after_conflict", 32'(tx_valid), 32'd0);
        end else begin
            checkOutput("tx_valid_latency1", 32'(tx_valid), 32'd1);
            if (tx_ready) begin
                step();
                model_seq = model_seq + 8'd1;
                checkOutput("seq_after_hs", 32'(seq), 32'(model_seq));
                checkOutput("ready_after_hs", 32'(req_ready), 32'd1);
                checkOutput("tx_valid_after_hs", 32'(tx_valid), 32'd0);
            end
        end
    endtask

    // Monitor: every handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_word", tx_data, 32'hxxxxxxxx);
            end else begin
                checkOutput("tx_data", tx_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] held;
        checks    = 0;
        failures  = 0;
        model_seq = 8'h00;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        tx_ready  = 1'b0;
        driveFlags(F_NONE, 8'h00);

        repeat (3) step();
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_tx_data", tx_data, 32'd0);
        checkOutput("rst_err", 32'(err_conflict), 32'd0);
        checkOutput("rst_seq", 32'(seq), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);

        rst_n = 1'b1;
        checkOutput("ready_before_first_edge", 32'(req_ready), 32'd0);
        step();
        checkOutput("ready_after_release", 32'(req_ready), 32'd1);

        tx_ready = 1'b1;
        applyStimulus(F_ON, 8'h33, 32'h41000041, 1'b0);
        checkOutput("seq_is_1", 32'(seq), 32'd1);
        applyStimulus(F_INC, 8'h10, 32'h55011044, 1'b0);

        applyStimulus(F_ON | F_OFF, 8'h00, 32'h0, 1'b1);
        applyStimulus(F_INC | F_DEC, 8'h22, 32'h0, 1'b1);
        applyStimulus(F_DEC | F_ON, 8'hA5, model_word(F_DEC | F_ON, 8'hA5, model_seq), 1'b0);

        // Stall with tx_ready low; junk on the request side must be ignored.
        tx_ready = 1'b0;
        held = model_word(F_SEND | F_RECV, 8'h77, model_seq);
        applyStimulus(F_SEND | F_RECV, 8'h77, held, 1'b0);
        req_valid = 1'b1;
        driveFlags(F_INC | F_OFF, 8'h99);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("stall_tx_data", tx_data, held);
            checkOutput("stall_tx_valid", 32'(tx_valid), 32'd1);
            checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
            checkOutput("stall_seq", 32'(seq), 32'(model_seq));
        end
        req_valid = 1'b0;
        driveFlags(F_NONE, 8'h00);
        tx_ready = 1'b1;
        step();
        model_seq = model_seq + 8'd1;
        checkOutput("seq_after_stall", 32'(seq), 32'(model_seq));

        // Reset in the middle of SEND drops the pending word.
        tx_ready = 1'b0;
        applyStimulus(F_OFF, 8'h01, model_word(F_OFF, 8'h01, model_seq), 1'b0);
        rst_n = 1'b0;
        step();
        checkOutput("midrst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("midrst_tx_data", tx_data, 32'd0);
        checkOutput("midrst_seq", 32'(seq), 32'd0);
        checkOutput("midrst_req_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        model_seq = 8'h00;
        rst_n = 1'b1;
        step();
        checkOutput("midrst_ready_after_release", 32'(req_ready), 32'd1);

        tx_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (model_seq == 8'hFF)
                applyStimulus(F_NONE, 8'h5A, 32'hBFFF0040, 1'b0);
            else
                applyStimulus(F_NONE, 8'h5A, model_word(F_NONE, 8'h00, model_seq), 1'b0);
        end
        checkOutput("seq_wrapped", 32'(seq), 32'd0);

        step();
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
